// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller request port between the loader,
// CPU data and CPU instruction-fetch requesters. One 16-bit word transaction
// is in flight at a time; a completion watchdog flags a stalled controller.
// Optional build macro SDRAM_ARB_RR_EN: data and instruction ports share
// round-robin between themselves (loader keeps absolute priority).
module sdram_arbiter #(
    parameter int ADDR_W  = 24,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_wdata,
    output logic              ld_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              d_ack,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [15:0]       rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_done,
    output logic              busy,
    output logic              timeout
);

    localparam int CNT_RAW = $clog2(TIMEOUT + 1);
    localparam int CNT_W   = (CNT_RAW > 10) ? CNT_RAW : 10;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [15:0]      STALL_DATA  = 16'hDEAD;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;
    typedef enum logic [1:0] {G_NONE, G_LD, G_D, G_I} grant_t;

    state_t           state, state_nx;
    grant_t           grant, win;
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_inc;
    logic             wd_expire;
`ifdef SDRAM_ARB_RR_EN
    logic             favour_i;   // 0: d preferred on a d/i tie, 1: i preferred
`endif

    assign wd_inc    = wd_cnt + CNT_ONE;
    assign wd_expire = (wd_inc == TIMEOUT_CNT);

    // Winner selection among the current requests; nothing wins while the controller is not ready
    always_comb begin
        win = G_NONE;
        if (mem_ready) begin
            if (ld_req)
                win = G_LD;
`ifdef SDRAM_ARB_RR_EN
            else if (d_req && i_req)
                win = favour_i ? G_I : G_D;
`endif
            else if (d_req)
                win = G_D;
            else if (i_req)
                win = G_I;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state and per-state outputs; acks are decoded from the latched grant
    always_comb begin
        state_nx = state;
        mem_req  = 1'b0;
        busy     = 1'b0;
        ld_ack   = 1'b0;
        d_ack    = 1'b0;
        i_ack    = 1'b0;
        case (state)
            S_IDLE: begin
                if (win != G_NONE)
                    state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                mem_req  = 1'b1;
                busy     = 1'b1;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_done || wd_expire)
                    state_nx = S_ACK;
            end
            S_ACK: begin
                ld_ack   = (grant == G_LD);
                d_ack    = (grant == G_D);
                i_ack    = (grant == G_I);
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Grant, watchdog counter, sticky timeout flag and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            grant   <= G_NONE;
            wd_cnt  <= '0;
            timeout <= 1'b0;
`ifdef SDRAM_ARB_RR_EN
            favour_i <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (win != G_NONE)
                        grant <= win;
                end
                S_WAIT: begin
                    wd_cnt <= wd_inc;
                    // A completion arriving on the expiry cycle still wins
                    if (!mem_done && wd_expire)
                        timeout <= 1'b1;
                end
                S_ACK: begin
                    wd_cnt <= '0;
`ifdef SDRAM_ARB_RR_EN
                    if (grant == G_D)
                        favour_i <= 1'b1;
                    else if (grant == G_I)
                        favour_i <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    // Transaction payload latched at grant; read data captured at completion or stall
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            if (state == S_IDLE) begin
                case (win)
                    G_LD: begin
                        mem_we    <= ld_we;
                        mem_addr  <= ld_addr;
                        mem_wdata <= ld_wdata;
                    end
                    G_D: begin
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                    end
                    G_I: begin
                        mem_we    <= 1'b0;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                    end
                    default: ;
                endcase
            end
            if (state == S_WAIT) begin
                if (mem_done) begin
                    if (!mem_we)
                        rdata <= mem_rdata;
                end else if (wd_expire) begin
                    rdata <= STALL_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed and randomized bench for sdram_arbiter. The bench
// plays the SDRAM controller and predicts each grant, ack and read value from
// a transaction-level model of the arbitration rules.
module tb_sdram_arbiter;

    localparam int AW  = 24;
    localparam int TMO = 15;

    logic          clk;
    logic          rst;
    logic          ld_req, ld_we, ld_ack;
    logic [AW-1:0] ld_addr;
    logic [15:0]   ld_wdata;
    logic          d_req, d_we, d_ack;
    logic [AW-1:0] d_addr;
    logic [15:0]   d_wdata;
    logic          i_req, i_ack;
    logic [AW-1:0] i_addr;
    logic [15:0]   rdata;
    logic          mem_ready, mem_req, mem_we, mem_done;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata, mem_rdata;
    logic          busy, timeout;

    int            total = 0;
    int            bad   = 0;

    // Reference state: sticky flag, last read value seen by requesters, last ack vector
    logic          tmo_m;
    logic [15:0]   rdata_m;
    logic [2:0]    last_acks;
`ifdef SDRAM_ARB_RR_EN
    logic          fav_i;
`endif

    sdram_arbiter #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
        .rdata(rdata),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .busy(busy), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which requester should be served: 0 = loader, 1 = data, 2 = instruction
    function automatic int model_pick(input logic l, input logic d, input logic i);
        if (l) return 0;
`ifdef SDRAM_ARB_RR_EN
        if (d && i) return fav_i ? 2 : 1;
`endif
        if (d) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        tmo_m   = 1'b0;
        rdata_m = 16'h0;
`ifdef SDRAM_ARB_RR_EN
        fav_i   = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; ld_req = 1'b0; d_req = 1'b0; i_req = 1'b0; mem_done = 1'b0;
        tick();
        chk("rst_ctl", {ld_ack, d_ack, i_ack, mem_req, mem_we, busy, timeout}, 7'b0);
        chk("rst_data", {mem_addr, mem_wdata, rdata}, '0);
        rst = 1'b0;
        model_reset();
    endtask

    // One full transaction starting from IDLE with requests already presented.
    // wait_cycles < 0 means the controller never completes.
    task automatic do_txn(input int wait_cycles, input logic [15:0] rd, input bit keep, input bit rnd);
        int            who;
        int            n;
        logic          we_e;
        logic [AW-1:0] a_e;
        logic [15:0]   wd_e;
        logic [2:0]    ack_e;
        who = model_pick(ld_req, d_req, i_req);
        case (who)
            0:       begin we_e = ld_we; a_e = ld_addr; wd_e = ld_wdata; ack_e = 3'b100; end
            1:       begin we_e = d_we;  a_e = d_addr;  wd_e = d_wdata;  ack_e = 3'b010; end
            default: begin we_e = 1'b0;  a_e = i_addr;  wd_e = 16'h0;    ack_e = 3'b001; end
        endcase
        tick();
        chk("issue_ctl", {mem_req, busy, ld_ack, d_ack, i_ack}, 5'b11000);
        chk("issue_addr", mem_addr, a_e);
        chk("issue_we", mem_we, we_e);
        if (we_e) chk("issue_wdata", mem_wdata, wd_e);
        if (rnd && $urandom_range(0, 1) == 1) begin
            mem_done = 1'b1; mem_rdata = 16'hBAD0;
        end
        tick();
        mem_done = 1'b0;
        n = (wait_cycles < 0) ? TMO : wait_cycles;
        for (int k = 0; k < n; k++) begin
            chk("wait_ctl", {mem_req, busy, ld_ack, d_ack, i_ack, timeout}, {5'b11000, tmo_m});
            chk("wait_hold", {mem_we, mem_addr}, {we_e, a_e});
            if (we_e) chk("wait_wdata", mem_wdata, wd_e);
            if (rnd) mem_ready = 1'($urandom_range(0, 1));
            tick();
        end
        if (wait_cycles >= 0) begin
            chk("wait_last", {mem_req, busy, ld_ack, d_ack, i_ack}, 5'b11000);
            mem_done = 1'b1; mem_rdata = rd;
            tick();
            mem_done = 1'b0; mem_rdata = 16'h0;
            if (!we_e) rdata_m = rd;
        end else begin
            tmo_m   = 1'b1;
            rdata_m = 16'hDEAD;
        end
        mem_ready = 1'b1;
        last_acks = {ld_ack, d_ack, i_ack};
        chk("ack_vec", {ld_ack, d_ack, i_ack}, ack_e);
        chk("ack_ctl", {mem_req, busy}, 2'b00);
        chk("ack_rdata", rdata, rdata_m);
        chk("ack_tmo", timeout, tmo_m);
`ifdef SDRAM_ARB_RR_EN
        if (who == 1) fav_i = 1'b1;
        else if (who == 2) fav_i = 1'b0;
`endif
        if (!keep) begin
            case (who)
                0:       ld_req = 1'b0;
                1:       d_req  = 1'b0;
                default: i_req  = 1'b0;
            endcase
        end
        tick();
        chk("idle_ctl", {mem_req, busy, ld_ack, d_ack, i_ack}, 5'b0);
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; mem_done = 1'b0; mem_rdata = 16'h0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = 16'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = 16'h0;
        i_req = 1'b0; i_addr = '0;
        last_acks = 3'b0;
        model_reset();
        tick();
        do_reset();

        // Instruction read, completion three cycles after mem_req rises
        i_req = 1'b1; i_addr = 24'h000005;
        do_txn(2, 16'h4041, 1'b0, 1'b0);
        chk("i_read_data", rdata, 16'h4041);

        // Data write leaves rdata untouched
        d_req = 1'b1; d_we = 1'b1; d_addr = 24'h00001F; d_wdata = 16'h6002;
        do_txn(1, 16'h7777, 1'b0, 1'b0);
        chk("d_write_rdata", rdata, 16'h4041);

        // All three together: served in priority order
        do_reset();
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 24'h000100; ld_wdata = 16'hA5A5;
        d_req  = 1'b1; d_we  = 1'b0; d_addr  = 24'h000200;
        i_req  = 1'b1; i_addr = 24'h000300;
        do_txn(2, 16'h1111, 1'b0, 1'b0);
        chk("order_first", last_acks, 3'b100);
        do_txn(2, 16'h2222, 1'b0, 1'b0);
        chk("order_second", last_acks, 3'b010);
        do_txn(2, 16'h3333, 1'b0, 1'b0);
        chk("order_third", last_acks, 3'b001);

        // Data and instruction held high across four transactions
        do_reset();
        d_req = 1'b1; d_we = 1'b0; d_addr = 24'h000011;
        i_req = 1'b1; i_addr = 24'h000022;
        for (int t = 0; t < 4; t++) begin
            do_txn(0, 16'(16'h0C00 + t), 1'b1, 1'b0);
`ifdef SDRAM_ARB_RR_EN
            chk("held_grant", last_acks, (t % 2 == 0) ? 3'b010 : 3'b001);
`else
            chk("held_grant", last_acks, 3'b010);
`endif
        end
        d_req = 1'b0; i_req = 1'b0;
        tick();

        // Stalled controller: watchdog fires, then a normal read still completes
        i_req = 1'b1; i_addr = 24'h000033;
        do_txn(-1, 16'h0, 1'b0, 1'b0);
        chk("tmo_data", rdata, 16'hDEAD);
        d_req = 1'b1; d_we = 1'b0; d_addr = 24'h000010;
        do_txn(0, 16'h5555, 1'b0, 1'b0);
        chk("tmo_sticky", timeout, 1'b1);

        // Controller not ready: request must wait
        mem_ready = 1'b0; i_req = 1'b1; i_addr = 24'h000044;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("notready", {mem_req, busy, i_ack}, 3'b000);
        end
        mem_ready = 1'b1;
        do_txn(1, 16'h9999, 1'b0, 1'b0);

        // Reset in the second wait cycle of a data write
        d_req = 1'b1; d_we = 1'b1; d_addr = 24'h000042; d_wdata = 16'h1234;
        tick();
        tick();
        tick();
        chk("midrst_pre", {mem_req, busy}, 2'b11);
        rst = 1'b1; d_req = 1'b0;
        tick();
        chk("midrst_ctl", {mem_req, busy, d_ack, timeout}, 4'b0000);
        rst = 1'b0;
        model_reset();
        tick();
        chk("midrst_after", {mem_req, busy, ld_ack, d_ack, i_ack}, 5'b0);

        // Randomized mix of requesters, payloads and controller latencies
        for (int t = 0; t < 40; t++) begin
            if (!ld_req && $urandom_range(0, 2) == 0) begin
                ld_req = 1'b1; ld_we = 1'($urandom_range(0, 1));
                ld_addr = AW'($urandom); ld_wdata = 16'($urandom);
            end
            if (!d_req && $urandom_range(0, 1) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = AW'($urandom); d_wdata = 16'($urandom);
            end
            if (!i_req && $urandom_range(0, 1) == 0) begin
                i_req = 1'b1; i_addr = AW'($urandom);
            end
            if (!ld_req && !d_req && !i_req) begin
                i_req = 1'b1; i_addr = AW'($urandom);
            end
            do_txn(int'($urandom_range(0, 5)), 16'($urandom), 1'b0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
